// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl
//   Session sequencer in front of the account/PIN authenticator:
//   card insert -> account FIND -> PIN AUTHENTICATE -> active session -> de-auth.
//   Requests to the authenticator are driven from registers, and the response
//   (auth_ok/auth_idx) is sampled two cycles later, in the *_CHK state.
//   Owns the PIN retry count, the idle timeout and (optionally) per-account lockout.
//
// Optional feature macro: ATM_LOCKOUT_EN
//   defined   : MAX_TRIES failed PINs lock the account until reset; later FINDs on it end with LOCKED.
//   undefined : no lockout bitmap; MAX_TRIES failures only end the current insertion with LOCKED.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   card_insert, card_acc[3:0]     card reader pulse + account number
//   pin_valid, pin_in[3:0]         keypad pulse + PIN
//   activity, logout               user activity (reloads idle timer) / user logout pulse
//   auth_ok, auth_idx[3:0]         authenticator response (wasSuccessful / accIndex)
//   auth_acc[3:0], auth_pin[3:0]   authenticator request (acc_number / pin)
//   auth_action, auth_deauth       authenticator action (0 FIND, 1 AUTHENTICATE) / deAuth pulse
//   pin_prompt, session_active     status: waiting for PIN / session open
//   session_acc[3:0]               authenticated account index
//   done, err_code[2:0]            end-of-attempt pulse + result code (held until next done)
//
// Done/err_code are registered: they appear in the first cycle of the state that
// follows the deciding cycle (e.g. together with pin_prompt after a bad PIN).

module atm_session_ctrl #(
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TIMER_W        = 10,
    parameter int unsigned NUM_ACCOUNTS   = 4,
    localparam int unsigned ACC_W         = 4,
    localparam int unsigned PIN_W         = 4,
    localparam int unsigned IDX_W         = 4,
    localparam int unsigned ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             card_insert,
    input  logic [ACC_W-1:0] card_acc,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin_in,
    input  logic             activity,
    input  logic             logout,
    input  logic             auth_ok,
    input  logic [IDX_W-1:0] auth_idx,
    output logic [ACC_W-1:0] auth_acc,
    output logic [PIN_W-1:0] auth_pin,
    output logic             auth_action,
    output logic             auth_deauth,
    output logic             pin_prompt,
    output logic             session_active,
    output logic [IDX_W-1:0] session_acc,
    output logic             done,
    output logic [ERR_W-1:0] err_code
);

    localparam int unsigned TRY_W = 3;

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TRY_W-1:0]   TRY_LIMIT  = TRY_W'(MAX_TRIES);

    localparam logic [ERR_W-1:0] ERR_OK      = ERR_W'(0);
    localparam logic [ERR_W-1:0] ERR_NO_ACCT = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_BAD_PIN = ERR_W'(2);
    localparam logic [ERR_W-1:0] ERR_LOCKED  = ERR_W'(3);
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = ERR_W'(4);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FIND_REQ = 3'd1,
        S_FIND_CHK = 3'd2,
        S_PIN_WAIT = 3'd3,
        S_AUTH_REQ = 3'd4,
        S_AUTH_CHK = 3'd5,
        S_SESSION  = 3'd6,
        S_LOGOUT   = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [TRY_W-1:0]   try_q, try_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic [ACC_W-1:0]   acc_d;
    logic [PIN_W-1:0]   pin_d;
    logic               action_d;
    logic               deauth_d;
    logic               prompt_d;
    logic               active_d;
    logic [IDX_W-1:0]   sess_acc_d;
    logic               done_d;
    logic [ERR_W-1:0]   err_d;

    logic [TRY_W-1:0]   try_inc;
    logic               timer_zero;
    logic               acct_locked;

    assign try_inc    = try_q + TRY_W'(1);
    assign timer_zero = (timer_q == '0);

`ifdef ATM_LOCKOUT_EN
    // Lockout bitmap: index captured at FIND, bit set on the final failed PIN.
    logic [NUM_ACCOUNTS-1:0] locked_q;
    logic [IDX_W-1:0]        lock_idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            if (state_q == S_FIND_CHK) begin
                lock_idx_q <= auth_idx;
            end
            if ((state_q == S_AUTH_CHK) && !auth_ok && (try_inc == TRY_LIMIT)) begin
                for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
                    if (lock_idx_q == IDX_W'(i)) begin
                        locked_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Out-of-range indices are never locked.
    always_comb begin
        acct_locked = 1'b0;
        for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
            if (locked_q[i] && (auth_idx == IDX_W'(i))) begin
                acct_locked = 1'b1;
            end
        end
    end
`else
    assign acct_locked = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            try_q          <= '0;
            timer_q        <= '0;
            auth_acc       <= '0;
            auth_pin       <= '0;
            auth_action    <= 1'b0;
            auth_deauth    <= 1'b0;
            pin_prompt     <= 1'b0;
            session_active <= 1'b0;
            session_acc    <= '0;
            done           <= 1'b0;
            err_code       <= '0;
        end else begin
            state_q        <= state_d;
            try_q          <= try_d;
            timer_q        <= timer_d;
            auth_acc       <= acc_d;
            auth_pin       <= pin_d;
            auth_action    <= action_d;
            auth_deauth    <= deauth_d;
            pin_prompt     <= prompt_d;
            session_active <= active_d;
            session_acc    <= sess_acc_d;
            done           <= done_d;
            err_code       <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        try_d      = try_q;
        timer_d    = timer_q;
        acc_d      = auth_acc;
        pin_d      = auth_pin;
        action_d   = auth_action;
        sess_acc_d = session_acc;
        done_d     = 1'b0;
        err_d      = err_code;

        case (state_q)
            S_IDLE: begin
                if (card_insert) begin
                    acc_d    = card_acc;
                    action_d = 1'b0;
                    try_d    = '0;
                    state_d  = S_FIND_REQ;
                end
            end

            S_FIND_REQ: state_d = S_FIND_CHK;

            S_FIND_CHK: begin
                if (!auth_ok) begin
                    done_d  = 1'b1;
                    err_d   = ERR_NO_ACCT;
                    state_d = S_IDLE;
                end else if (acct_locked) begin
                    done_d  = 1'b1;
                    err_d   = ERR_LOCKED;
                    state_d = S_IDLE;
                end else begin
                    timer_d = TIMER_LOAD;
                    state_d = S_PIN_WAIT;
                end
            end

            // A PIN arriving in the expiry cycle still counts.
            S_PIN_WAIT: begin
                if (pin_valid) begin
                    pin_d    = pin_in;
                    action_d = 1'b1;
                    state_d  = S_AUTH_REQ;
                end else if (timer_zero) begin
                    done_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                    state_d = S_LOGOUT;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            S_AUTH_REQ: state_d = S_AUTH_CHK;

            S_AUTH_CHK: begin
                done_d = 1'b1;
                if (auth_ok) begin
                    sess_acc_d = auth_idx;
                    err_d      = ERR_OK;
                    timer_d    = TIMER_LOAD;
                    state_d    = S_SESSION;
                end else begin
                    try_d = try_inc;
                    if (try_inc == TRY_LIMIT) begin
                        err_d   = ERR_LOCKED;
                        state_d = S_LOGOUT;
                    end else begin
                        err_d   = ERR_BAD_PIN;
                        timer_d = TIMER_LOAD;
                        state_d = S_PIN_WAIT;
                    end
                end
            end

            // Logout beats activity; activity in the expiry cycle keeps the session.
            S_SESSION: begin
                if (logout) begin
                    done_d  = 1'b1;
                    err_d   = ERR_OK;
                    state_d = S_LOGOUT;
                end else if (activity) begin
                    timer_d = TIMER_LOAD;
                end else if (timer_zero) begin
                    done_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                    state_d = S_LOGOUT;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            S_LOGOUT: begin
                sess_acc_d = '0;
                pin_d      = '0;
                try_d      = '0;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Status outputs follow the state being entered so they line up with it.
        prompt_d = (state_d == S_PIN_WAIT);
        active_d = (state_d == S_SESSION);
        deauth_d = (state_d == S_LOGOUT);
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl
//   Self-checking bench for atm_session_ctrl. A stub authenticator knows accounts
//   0..3 (index = account number, PIN = account number). Expected behaviour is
//   derived per transaction from the session rules: account table, try count,
//   consecutive idle-cycle count and a lockout set.

module tb_atm_session_ctrl;

    localparam int MAX_TRIES = 3;
    localparam int T         = 16;
    localparam int NUM_ACC   = 4;

`ifdef ATM_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       card_insert;
    logic [3:0] card_acc;
    logic       pin_valid;
    logic [3:0] pin_in;
    logic       activity;
    logic       logout;
    logic       auth_ok;
    logic [3:0] auth_idx;
    logic [3:0] auth_acc;
    logic [3:0] auth_pin;
    logic       auth_action;
    logic       auth_deauth;
    logic       pin_prompt;
    logic       session_active;
    logic [3:0] session_acc;
    logic       done;
    logic [2:0] err_code;

    int n_checks = 0;
    int n_pass   = 0;
    bit locked_m [NUM_ACC];

    always #5 clk = ~clk;

    atm_session_ctrl #(
        .MAX_TRIES     (MAX_TRIES),
        .TIMEOUT_CYCLES(T),
        .TIMER_W       (4),
        .NUM_ACCOUNTS  (NUM_ACC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .card_insert   (card_insert),
        .card_acc      (card_acc),
        .pin_valid     (pin_valid),
        .pin_in        (pin_in),
        .activity      (activity),
        .logout        (logout),
        .auth_ok       (auth_ok),
        .auth_idx      (auth_idx),
        .auth_acc      (auth_acc),
        .auth_pin      (auth_pin),
        .auth_action   (auth_action),
        .auth_deauth   (auth_deauth),
        .pin_prompt    (pin_prompt),
        .session_active(session_active),
        .session_acc   (session_acc),
        .done          (done),
        .err_code      (err_code)
    );

    // Stub authenticator: accounts 0..3 exist, PIN equals the account number.
    always_comb begin
        auth_idx = auth_acc;
        if (auth_acc >= 4'(NUM_ACC)) auth_ok = 1'b0;
        else if (auth_action)        auth_ok = (auth_pin == auth_acc);
        else                         auth_ok = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        card_insert = 1'b0;
        pin_valid   = 1'b0;
        activity    = 1'b0;
        logout      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acc"},      32'(auth_acc), 32'd0);
        check({tag, "_pin"},      32'(auth_pin), 32'd0);
        check({tag, "_action"},   32'(auth_action), 32'd0);
        check({tag, "_deauth"},   32'(auth_deauth), 32'd0);
        check({tag, "_prompt"},   32'(pin_prompt), 32'd0);
        check({tag, "_active"},   32'(session_active), 32'd0);
        check({tag, "_sess_acc"}, 32'(session_acc), 32'd0);
        check({tag, "_done"},     32'(done), 32'd0);
        check({tag, "_err"},      32'(err_code), 32'd0);
    endtask

    // Insert a card; ends in the first PIN_WAIT cycle (entered=1) or back in IDLE.
    task automatic insert_card(input logic [3:0] acc, output bit entered);
        card_acc    = acc;
        card_insert = 1'b1;
        step();
        card_insert = 1'b0;
        card_acc    = 4'($urandom);
        check("find_acc", 32'(auth_acc), 32'(acc));
        check("find_action", 32'(auth_action), 32'd0);
        check("find_prompt_early", 32'(pin_prompt), 32'd0);
        step();
        check("find_done_early", 32'(done), 32'd0);
        step();
        entered = 1'b0;
        if (acc >= 4'(NUM_ACC)) begin
            check("noacct_done", 32'(done), 32'd1);
            check("noacct_err", 32'(err_code), 32'd1);
            check("noacct_prompt", 32'(pin_prompt), 32'd0);
        end else if (locked_m[acc]) begin
            check("locked_done", 32'(done), 32'd1);
            check("locked_err", 32'(err_code), 32'd3);
            check("locked_prompt", 32'(pin_prompt), 32'd0);
        end else begin
            check("prompt_at3", 32'(pin_prompt), 32'd1);
            check("prompt_done", 32'(done), 32'd0);
            entered = 1'b1;
        end
        if (!entered) begin
            step();
            check("find_end_done_pulse", 32'(done), 32'd0);
            check("find_end_deauth", 32'(auth_deauth), 32'd0);
            check("find_end_prompt", 32'(pin_prompt), 32'd0);
        end
    endtask

    // One PIN attempt from the first PIN_WAIT cycle. oc: 0 session, 1 retry, 2 locked out.
    task automatic try_pin(input logic [3:0] acc, input logic [3:0] pin, input int wait_n,
                           inout int tries, output int oc);
        repeat (wait_n) begin
            card_insert = ($urandom_range(0, 3) == 0);
            card_acc    = 4'($urandom);
            activity    = $urandom_range(0, 1) == 1;
            step();
        end
        clear_inputs();
        check("pw_prompt", 32'(pin_prompt), 32'd1);
        pin_in    = pin;
        pin_valid = 1'b1;
        step();
        pin_valid = 1'b0;
        pin_in    = 4'($urandom);
        check("authreq_prompt", 32'(pin_prompt), 32'd0);
        check("authreq_pin", 32'(auth_pin), 32'(pin));
        check("authreq_action", 32'(auth_action), 32'd1);
        step();
        check("authchk_active", 32'(session_active), 32'd0);
        check("authchk_done", 32'(done), 32'd0);
        step();
        if (pin == acc) begin
            check("auth_ok_active", 32'(session_active), 32'd1);
            check("auth_ok_done", 32'(done), 32'd1);
            check("auth_ok_err", 32'(err_code), 32'd0);
            check("auth_ok_sess_acc", 32'(session_acc), 32'(acc));
            oc = 0;
        end else begin
            tries++;
            check("badpin_done", 32'(done), 32'd1);
            check("badpin_active", 32'(session_active), 32'd0);
            if (tries == MAX_TRIES) begin
                check("maxtries_err", 32'(err_code), 32'd3);
                check("maxtries_deauth", 32'(auth_deauth), 32'd1);
                check("maxtries_prompt", 32'(pin_prompt), 32'd0);
                if (LOCK_EN) locked_m[acc] = 1'b1;
                step();
                check("maxtries_deauth_pulse", 32'(auth_deauth), 32'd0);
                check("maxtries_done_pulse", 32'(done), 32'd0);
                check("maxtries_pin_clr", 32'(auth_pin), 32'd0);
                oc = 2;
            end else begin
                check("badpin_err", 32'(err_code), 32'd2);
                check("badpin_prompt", 32'(pin_prompt), 32'd1);
                check("badpin_deauth", 32'(auth_deauth), 32'd0);
                oc = 1;
            end
        end
    endtask

    // Let PIN_WAIT expire from its first cycle (activity must not extend it).
    task automatic pin_timeout();
        repeat (T - 1) begin
            card_insert = ($urandom_range(0, 3) == 0);
            activity    = $urandom_range(0, 1) == 1;
            logout      = $urandom_range(0, 3) == 0;
            step();
        end
        clear_inputs();
        check("pw_last_prompt", 32'(pin_prompt), 32'd1);
        check("pw_last_done", 32'(done), 32'd0);
        step();
        check("pw_to_done", 32'(done), 32'd1);
        check("pw_to_err", 32'(err_code), 32'd4);
        check("pw_to_deauth", 32'(auth_deauth), 32'd1);
        check("pw_to_prompt", 32'(pin_prompt), 32'd0);
        step();
        check("pw_to_deauth_pulse", 32'(auth_deauth), 32'd0);
        check("pw_to_done_pulse", 32'(done), 32'd0);
    endtask

    // Run a session from its first cycle. mode 0 busy, 1 quiet (times out), 2 logout+activity at once.
    task automatic session_phase(input logic [3:0] acc, input int mode);
        int idle_run;
        bit ended;
        int exp_err;
        bit act, lo;
        idle_run = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            act = (mode == 2) || ((mode == 0) && ($urandom_range(0, 2) == 0));
            lo  = (mode == 2) || (cyc == 299) || ((mode == 0) && ($urandom_range(0, 60) == 0));
            activity    = act;
            logout      = lo;
            card_insert = ($urandom_range(0, 7) == 0);
            card_acc    = 4'($urandom);
            pin_valid   = ($urandom_range(0, 7) == 0);
            pin_in      = 4'($urandom);
            ended   = 1'b0;
            exp_err = 0;
            if (lo) begin
                ended = 1'b1;
            end else if (act) begin
                idle_run = 0;
            end else begin
                idle_run++;
                if (idle_run == T) begin
                    ended   = 1'b1;
                    exp_err = 4;
                end
            end
            step();
            clear_inputs();
            if (ended) begin
                check("sess_end_done", 32'(done), 32'd1);
                check("sess_end_err", 32'(err_code), 32'(exp_err));
                check("sess_end_active", 32'(session_active), 32'd0);
                check("sess_end_deauth", 32'(auth_deauth), 32'd1);
                step();
                check("sess_end_deauth_pulse", 32'(auth_deauth), 32'd0);
                check("sess_end_sess_acc", 32'(session_acc), 32'd0);
                check("sess_end_pin_clr", 32'(auth_pin), 32'd0);
                check("sess_end_done_pulse", 32'(done), 32'd0);
                return;
            end
            check("sess_active", 32'(session_active), 32'd1);
            check("sess_done", 32'(done), 32'd0);
            check("sess_acc_hold", 32'(session_acc), 32'(acc));
        end
    endtask

    initial begin
        bit   entered;
        int   tries;
        int   oc;
        logic [3:0] acc;
        logic [3:0] pin;
        int   wait_n;

        clear_inputs();
        card_acc = '0;
        pin_in   = '0;
        rst_n    = 1'b0;
        for (int i = 0; i < NUM_ACC; i++) locked_m[i] = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Good account, good PIN, logout together with activity.
        insert_card(4'd2, entered);
        tries = 0;
        if (entered) try_pin(4'd2, 4'd2, 0, tries, oc);
        if (entered && oc == 0) session_phase(4'd2, 2);

        // Unknown account.
        insert_card(4'd9, entered);

        // Three bad PINs, then reinsert the same account.
        insert_card(4'd1, entered);
        tries = 0;
        if (entered) try_pin(4'd1, 4'd5, 1, tries, oc);
        if (entered) try_pin(4'd1, 4'd6, 0, tries, oc);
        if (entered) try_pin(4'd1, 4'd7, 2, tries, oc);
        insert_card(4'd1, entered);
        tries = 0;
        if (entered) try_pin(4'd1, 4'd1, 0, tries, oc);
        if (entered && oc == 0) session_phase(4'd1, 1);

        // PIN_WAIT timeout, then a PIN landing exactly on the expiry cycle.
        insert_card(4'd3, entered);
        if (entered) pin_timeout();
        insert_card(4'd3, entered);
        tries = 0;
        if (entered) try_pin(4'd3, 4'd3, T - 1, tries, oc);
        if (entered && oc == 0) session_phase(4'd3, 0);

        // Reset while the AUTHENTICATE request is in flight.
        insert_card(4'd2, entered);
        if (entered) begin
            pin_in    = 4'd2;
            pin_valid = 1'b1;
            step();
            pin_valid = 1'b0;
        end
        rst_n = 1'b0;
        step();
        check_all_zero("midreset");
        rst_n = 1'b1;
        for (int i = 0; i < NUM_ACC; i++) locked_m[i] = 1'b0;
        step();
        check("post_reset_deauth", 32'(auth_deauth), 32'd0);
        check("post_reset_prompt", 32'(pin_prompt), 32'd0);
        insert_card(4'd1, entered);
        if (entered) pin_timeout();

        // Random insertions.
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 3)) begin
                activity  = $urandom_range(0, 1) == 1;
                logout    = $urandom_range(0, 1) == 1;
                pin_valid = $urandom_range(0, 1) == 1;
                step();
                check("idle_done", 32'(done), 32'd0);
                check("idle_prompt", 32'(pin_prompt), 32'd0);
            end
            clear_inputs();
            if ($urandom_range(0, 5) == 0) acc = 4'($urandom_range(4, 15));
            else                           acc = 4'($urandom_range(0, NUM_ACC - 1));
            insert_card(acc, entered);
            if (!entered) continue;
            if ($urandom_range(0, 7) == 0) begin
                pin_timeout();
            end else begin
                tries = 0;
                oc    = 1;
                while (oc == 1) begin
                    pin    = ($urandom_range(0, 1) == 1) ? acc : 4'($urandom);
                    wait_n = ($urandom_range(0, 3) == 0) ? T - 1 : int'($urandom_range(0, 4));
                    try_pin(acc, pin, wait_n, tries, oc);
                end
                if (oc == 0) session_phase(acc, ($urandom_range(0, 3) == 0) ? 1 : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
